// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared types for the two-input stream arbiter.
//   arb_state_t : arbiter FSM states (no grant, A granted, B granted)
//   src_t       : source identifier carried with every beat (A = 0, B = 1)
package stream_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    // Source that gets the next tie-break after `served` releases its grant.
    function automatic src_t other_src(input src_t served);
        return (served == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/skid_buf_2.sv
// skid_buf_2: 2-entry valid/ready register slice (shift-register FIFO).
//   clk_in, rst_in       : clock, synchronous active-high reset (empties the slice)
//   in_valid/in_data     : upstream beat; pushed when in_ready
//   in_ready             : !full, registered-state only (no path from out_ready)
//   out_valid/out_data   : head entry
//   out_ready            : downstream accepts the head entry
module skid_buf_2 #(
    parameter int unsigned DW = 10
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    logic [DW-1:0] ent0_q, ent0_d;
    logic [DW-1:0] ent1_q, ent1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = ent0_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = in_data;
                end else begin
                    ent1_d = in_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Push requires !full, so occupancy is 0 or 1 here; only 1 can pop.
                if (cnt_q == 2'd1) begin
                    ent0_d = in_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/stream_arb_21.sv
// stream_arb_21: two-input round-robin stream arbiter with packet locking and a
// registered, skid-buffered output. sel_out steers the downstream 2:1 mux.
//   clk_in, rst_in                   : clock, synchronous active-high reset
//   a_valid/data/last_in, a_ready_out: source A stream
//   b_valid/data/last_in, b_ready_out: source B stream
//   y_valid/data/last/src_out, y_ready_in : arbitrated output stream
//   sel_out                          : registered grant (1 only while B granted)
module stream_arb_21
    import stream_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          LOCK_PKT = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             a_valid_in,
    input  logic [WIDTH-1:0] a_data_in,
    input  logic             a_last_in,
    output logic             a_ready_out,
    input  logic             b_valid_in,
    input  logic [WIDTH-1:0] b_data_in,
    input  logic             b_last_in,
    output logic             b_ready_out,
    output logic             y_valid_out,
    output logic [WIDTH-1:0] y_data_out,
    output logic             y_last_out,
    output logic             y_src_out,
    input  logic             y_ready_in,
    output logic             sel_out
);

    localparam int unsigned PW = WIDTH + 2;

    arb_state_t    state_q;
    src_t          pri_q;
    logic          sel_q;

    logic          buf_in_ready;
    logic          push_valid;
    logic [PW-1:0] push_data;
    logic [PW-1:0] pop_data;
    logic          acc_a, acc_b;
    logic          rel_a, rel_b;

    // Readies depend only on the registered grant and buffer occupancy.
    assign a_ready_out = (state_q == GRANT_A) && buf_in_ready;
    assign b_ready_out = (state_q == GRANT_B) && buf_in_ready;
    assign acc_a       = a_valid_in && a_ready_out;
    assign acc_b       = b_valid_in && b_ready_out;
    assign rel_a       = acc_a && (!LOCK_PKT || a_last_in);
    assign rel_b       = acc_b && (!LOCK_PKT || b_last_in);

    assign push_valid = ((state_q == GRANT_A) && a_valid_in) ||
                        ((state_q == GRANT_B) && b_valid_in);
    assign push_data  = (state_q == GRANT_B) ? {SRC_B, b_last_in, b_data_in}
                                             : {SRC_A, a_last_in, a_data_in};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            pri_q   <= SRC_A;
            sel_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (a_valid_in && (!b_valid_in || pri_q == SRC_A)) begin
                        state_q <= GRANT_A;
                        sel_q   <= 1'b0;
                    end else if (b_valid_in) begin
                        state_q <= GRANT_B;
                        sel_q   <= 1'b1;
                    end
                end
                GRANT_A: begin
                    if (rel_a) begin
                        pri_q <= other_src(SRC_A);
                        if (b_valid_in) begin
                            state_q <= GRANT_B;
                            sel_q   <= 1'b1;
                        end else if (a_valid_in) begin
                            state_q <= GRANT_A;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GRANT_B: begin
                    if (rel_b) begin
                        pri_q <= other_src(SRC_B);
                        if (a_valid_in) begin
                            state_q <= GRANT_A;
                            sel_q   <= 1'b0;
                        end else if (b_valid_in) begin
                            state_q <= GRANT_B;
                        end else begin
                            state_q <= IDLE;
                            sel_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sel_q   <= 1'b0;
                end
            endcase
        end
    end

    skid_buf_2 #(
        .DW(PW)
    ) u_skid (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .in_valid (push_valid),
        .in_data  (push_data),
        .in_ready (buf_in_ready),
        .out_valid(y_valid_out),
        .out_data (pop_data),
        .out_ready(y_ready_in)
    );

    assign y_data_out = pop_data[WIDTH-1:0];
    assign y_last_out = pop_data[WIDTH];
    assign y_src_out  = pop_data[WIDTH+1];
    assign sel_out    = sel_q;

endmodule

// File: tb/tb_stream_arb_21.sv
// Bench for stream_arb_21: u0 has LOCK_PKT=0, u1 has LOCK_PKT=1, both driven by
// the same inputs and both compared every cycle against a queue-based model.
module tb_stream_arb_21;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, av, al, bv, bl, yr;
    logic [W-1:0] ad, bd;
    logic [1:0]   ar, br, yv, yl, ys, sel;
    logic [W-1:0] yd [2];

    stream_arb_21 #(.WIDTH(W), .LOCK_PKT(1'b0)) u0 (
        .clk_in(clk), .rst_in(rst),
        .a_valid_in(av), .a_data_in(ad), .a_last_in(al), .a_ready_out(ar[0]),
        .b_valid_in(bv), .b_data_in(bd), .b_last_in(bl), .b_ready_out(br[0]),
        .y_valid_out(yv[0]), .y_data_out(yd[0]), .y_last_out(yl[0]),
        .y_src_out(ys[0]), .y_ready_in(yr), .sel_out(sel[0])
    );

    stream_arb_21 #(.WIDTH(W), .LOCK_PKT(1'b1)) u1 (
        .clk_in(clk), .rst_in(rst),
        .a_valid_in(av), .a_data_in(ad), .a_last_in(al), .a_ready_out(ar[1]),
        .b_valid_in(bv), .b_data_in(bd), .b_last_in(bl), .b_ready_out(br[1]),
        .y_valid_out(yv[1]), .y_data_out(yd[1]), .y_last_out(yl[1]),
        .y_src_out(ys[1]), .y_ready_in(yr), .sel_out(sel[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: grant 0=A, 1=B, 2=none; output buffer as a queue of {src,last,data}.
    int           m_grant [2];
    int           m_pri   [2];
    logic [W+1:0] m_q     [2][$];
    bit           m_ok = 1'b0;

    // Sampled copies for sequence checks, and captured output beats {src,data}.
    logic [1:0]   s_ar, s_br, s_yv, s_sel;
    logic [W:0]   out0 [$];
    logic [W:0]   out1 [$];

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            bit ea, eb;
            ea = (m_grant[i] == 0) && (m_q[i].size() < 2);
            eb = (m_grant[i] == 1) && (m_q[i].size() < 2);
            chk($sformatf("u%0d.a_ready", i), ar[i], ea);
            chk($sformatf("u%0d.b_ready", i), br[i], eb);
            chk($sformatf("u%0d.sel", i), sel[i], m_grant[i] == 1);
            chk($sformatf("u%0d.y_valid", i), yv[i], m_q[i].size() > 0);
            if (m_q[i].size() > 0) begin
                chk($sformatf("u%0d.y_data", i), yd[i], m_q[i][0][W-1:0]);
                chk($sformatf("u%0d.y_last", i), yl[i], m_q[i][0][W]);
                chk($sformatf("u%0d.y_src", i), ys[i], m_q[i][0][W+1]);
            end
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit ea, eb, acc_a, acc_b, lock;
            lock = (i == 1);
            if (rst) begin
                m_grant[i] = 2;
                m_pri[i]   = 0;
                m_q[i].delete();
            end else if (m_ok) begin
                ea    = (m_grant[i] == 0) && (m_q[i].size() < 2);
                eb    = (m_grant[i] == 1) && (m_q[i].size() < 2);
                acc_a = av && ea;
                acc_b = bv && eb;
                if (m_q[i].size() > 0 && yr) void'(m_q[i].pop_front());
                if (acc_a) m_q[i].push_back({1'b0, al, ad});
                if (acc_b) m_q[i].push_back({1'b1, bl, bd});
                case (m_grant[i])
                    2: begin
                        if (av && bv) m_grant[i] = m_pri[i];
                        else if (av)  m_grant[i] = 0;
                        else if (bv)  m_grant[i] = 1;
                    end
                    0: if (acc_a && (!lock || al)) begin
                        m_pri[i]   = 1;
                        m_grant[i] = bv ? 1 : (av ? 0 : 2);
                    end
                    1: if (acc_b && (!lock || bl)) begin
                        m_pri[i]   = 0;
                        m_grant[i] = av ? 0 : (bv ? 1 : 2);
                    end
                    default: ;
                endcase
            end
        end
        if (rst) m_ok = 1'b1;
    endtask

    // Inputs are set by the caller just after a negedge; one full clock follows.
    task automatic cycle();
        #1;
        s_ar  = ar;
        s_br  = br;
        s_yv  = yv;
        s_sel = sel;
        if (yv[0] && yr) out0.push_back({ys[0], yd[0]});
        if (yv[1] && yr) out1.push_back({ys[1], yd[1]});
        if (m_ok) check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; av = 1'b0; bv = 1'b0; al = 1'b0; bl = 1'b0; yr = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic rst, av; logic [7:0] ad; logic al, bv; logic [7:0] bd; logic bl, yr;
        logic chk_en;
        logic ar, br, yv; logic [7:0] yd; logic yl, ys, sel;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt, cyc, na, nb;
        rst = 1'b1; av = 1'b0; bv = 1'b0; al = 1'b0; bl = 1'b0; yr = 1'b1;
        ad = '0; bd = '0;

        // Reset with both valid, then tie round-robin of 2-beat packets (checked on u1).
        tbl[0] = '{1, 1, 8'h11, 0, 1, 8'h21, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[1] = '{1, 1, 8'h11, 0, 1, 8'h21, 0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[2] = '{1, 1, 8'h11, 0, 1, 8'h21, 0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[3] = '{0, 1, 8'h11, 0, 1, 8'h21, 0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[4] = '{0, 1, 8'h11, 0, 1, 8'h21, 0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0};
        tbl[5] = '{0, 1, 8'h12, 1, 1, 8'h21, 0, 1, 1, 1, 0, 1, 8'h11, 0, 0, 0};
        tbl[6] = '{0, 1, 8'h11, 0, 1, 8'h21, 0, 1, 1, 0, 1, 1, 8'h12, 1, 0, 1};
        tbl[7] = '{0, 1, 8'h11, 0, 1, 8'h22, 1, 1, 1, 0, 1, 1, 8'h21, 0, 1, 1};
        tbl[8] = '{0, 1, 8'h11, 0, 1, 8'h21, 0, 1, 1, 1, 0, 1, 8'h22, 1, 1, 0};
        tbl[9] = '{0, 1, 8'h12, 1, 1, 8'h21, 0, 1, 1, 1, 0, 1, 8'h11, 0, 0, 0};

        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            rst = tbl[k].rst; av = tbl[k].av; ad = tbl[k].ad; al = tbl[k].al;
            bv = tbl[k].bv; bd = tbl[k].bd; bl = tbl[k].bl; yr = tbl[k].yr;
            #1;
            if (tbl[k].chk_en) begin
                chk($sformatf("tbl%0d.a_ready", k), ar[1], tbl[k].ar);
                chk($sformatf("tbl%0d.b_ready", k), br[1], tbl[k].br);
                chk($sformatf("tbl%0d.y_valid", k), yv[1], tbl[k].yv);
                chk($sformatf("tbl%0d.y_data", k), yd[1], tbl[k].yd);
                chk($sformatf("tbl%0d.y_last", k), yl[1], tbl[k].yl);
                chk($sformatf("tbl%0d.y_src", k), ys[1], tbl[k].ys);
                chk($sformatf("tbl%0d.sel", k), sel[1], tbl[k].sel);
            end
            cycle();
        end

        // Packet lock: B arrives mid-way through A's 4-beat packet.
        do_reset();
        av = 1; ad = 8'h31; al = 0; bv = 0; bd = 8'h41; bl = 1; yr = 1;
        cycle();
        cycle();
        chk("lock.a_first", s_ar[1], 1);
        ad = 8'h32;
        cycle();
        ad = 8'h33; bv = 1;
        cycle();
        chk("lock.b_held3", s_br[1], 0);
        chk("lock.sel3", s_sel[1], 0);
        ad = 8'h34; al = 1;
        cycle();
        chk("lock.b_held4", s_br[1], 0);
        chk("lock.a_last", s_ar[1], 1);
        av = 0; al = 0;
        cycle();
        chk("lock.sel_b", s_sel[1], 1);
        chk("lock.b_ready", s_br[1], 1);
        bv = 0;
        cycle();

        // Backpressure: 5 stall cycles inside a stream of 0x01..0x08 on u1.
        do_reset();
        out1.delete();
        nxt = 1; cyc = 0;
        while (out1.size() < 8 && cyc < 60) begin
            av = (nxt <= 8); ad = nxt[W-1:0]; al = (nxt == 8); bv = 0;
            yr = !(cyc >= 5 && cyc < 10);
            cycle();
            if (cyc >= 6 && cyc < 10) chk($sformatf("bp.ready_low%0d", cyc), s_ar[1], 0);
            if (s_ar[1] && av) nxt++;
            cyc++;
        end
        av = 0; yr = 1;
        chk("bp.count", out1.size(), 8);
        for (int k = 0; k < 8 && k < out1.size(); k++)
            chk($sformatf("bp.beat%0d", k), out1[k], {1'b0, 8'(k + 1)});

        // LOCK_PKT=0 on u0: both always valid, single-beat alternation.
        do_reset();
        out0.delete();
        na = 0; nb = 0; cyc = 0;
        while (out0.size() < 8 && cyc < 40) begin
            av = 1; ad = 8'hA0 + 8'(na); al = 0;
            bv = 1; bd = 8'hB0 + 8'(nb); bl = 0; yr = 1;
            cycle();
            if (s_ar[0]) na++;
            if (s_br[0]) nb++;
            cyc++;
        end
        chk("alt.count", out0.size(), 8);
        for (int k = 0; k < 8 && k < out0.size(); k++)
            chk($sformatf("alt.beat%0d", k), out0[k],
                (k % 2 == 0) ? {1'b0, 8'hA0 + 8'(k / 2)} : {1'b1, 8'hB0 + 8'(k / 2)});

        // Reset with two beats buffered on u1.
        do_reset();
        av = 1; ad = 8'h51; al = 0; bv = 0; yr = 0;
        cycle();
        cycle();
        ad = 8'h52;
        cycle();
        ad = 8'h53;
        cycle();
        chk("rstmid.full", s_ar[1], 0);
        chk("rstmid.buffered", s_yv[1], 1);
        rst = 1;
        cycle();
        rst = 0; av = 0; bv = 0; yr = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("rstmid.yv1_%0d", k), s_yv[1], 0);
            chk($sformatf("rstmid.yv0_%0d", k), s_yv[0], 0);
            chk($sformatf("rstmid.sel_%0d", k), s_sel[1], 0);
        end
        av = 1; ad = 8'h61; bv = 1; bd = 8'h71;
        cycle();
        cycle();
        chk("rstmid.pri_a", s_ar[1], 1);
        chk("rstmid.pri_b", s_br[1], 0);
        chk("rstmid.pri_sel", s_sel[1], 0);

        // Random traffic with occasional resets, checked against the model.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            av  = ($urandom_range(0, 9) < 7);
            ad  = W'($urandom);
            al  = ($urandom_range(0, 2) == 0);
            bv  = ($urandom_range(0, 9) < 7);
            bd  = W'($urandom);
            bl  = ($urandom_range(0, 2) == 0);
            yr  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
